// File: rtl/dmem_if.sv
// Request/response bus between a load/store initiator and the data-memory responder.
// Both channels use a valid/ready handshake that completes on the rising edge where valid && ready.
interface dmem_if #(
  parameter int ADDRESS_BITS = 32
);
  // Valid/ready rule: the source holds valid and its payload until the edge where ready is high.
  logic                    req_valid;
  logic                    req_ready;
  logic [ADDRESS_BITS-1:0] req_addr;
  logic                    req_wen;
  logic [1:0]              req_size;
  logic                    req_sign;
  logic [31:0]             req_wdata;
  logic                    resp_valid;
  logic                    resp_ready;
  logic [31:0]             resp_rdata;
  logic                    resp_err;

  modport slave (
    input  req_valid, req_addr, req_wen, req_size, req_sign, req_wdata, resp_ready,
    output req_ready, resp_valid, resp_rdata, resp_err
  );

  modport master (
    output req_valid, req_addr, req_wen, req_size, req_sign, req_wdata, resp_ready,
    input  req_ready, resp_valid, resp_rdata, resp_err
  );
endinterface

// File: rtl/dmem_responder.sv
// Single-outstanding data-memory responder: fixed-latency byte/half/word loads and stores
// with alignment and range faults. Storage is not reset.
module dmem_responder #(
  parameter int ADDRESS_BITS = 32,
  parameter int DEPTH_WORDS  = 1024,
  parameter int LATENCY      = 2
) (
  input  logic       clk,
  input  logic       rst,
  dmem_if.slave      bus,
  output logic [1:0] dbg_state_o
);

  localparam int                      IDX_W    = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam bit                      LAT_ONE  = (LATENCY == 1);
  localparam logic [3:0]              CNT_LOAD = 4'(LATENCY - 1);
  localparam logic [ADDRESS_BITS-3:0] DEPTH_L  = (ADDRESS_BITS-2)'(DEPTH_WORDS);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_e;

  state_e                  state_q, state_d;
  logic [3:0]              cnt_q, cnt_d;
  logic [ADDRESS_BITS-1:0] addr_q;
  logic                    wen_q;
  logic [1:0]              size_q;
  logic                    sign_q;
  logic [31:0]             wdata_q;
  logic                    resp_valid_q, resp_valid_d;
  logic [31:0]             rdata_q, rdata_d;
  logic                    err_q, err_d;
  logic [31:0]             mem_q [DEPTH_WORDS];

  logic                    accept;
  logic                    enter_resp;
  logic [ADDRESS_BITS-1:0] x_addr;
  logic                    x_wen;
  logic [1:0]              x_size;
  logic                    x_sign;
  logic [31:0]             x_wdata;
  logic [IDX_W-1:0]        x_idx;
  logic                    x_err;
  logic [31:0]             x_word;
  logic [7:0]              x_byte;
  logic [15:0]             x_half;
  logic [31:0]             x_load;
  logic [3:0]              x_be;
  logic [31:0]             x_lanes;

  assign bus.req_ready  = (state_q == S_IDLE);
  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_rdata = rdata_q;
  assign bus.resp_err   = err_q;
  assign dbg_state_o    = state_q;
  assign accept         = bus.req_valid && bus.req_ready;

  // With LATENCY = 1 the commit edge is the acceptance edge, so the live request is used.
  always_comb begin
    if (state_q == S_IDLE) begin
      x_addr  = bus.req_addr;
      x_wen   = bus.req_wen;
      x_size  = bus.req_size;
      x_sign  = bus.req_sign;
      x_wdata = bus.req_wdata;
    end else begin
      x_addr  = addr_q;
      x_wen   = wen_q;
      x_size  = size_q;
      x_sign  = sign_q;
      x_wdata = wdata_q;
    end
  end

  always_comb begin
    x_idx  = x_addr[IDX_W+1:2];
    x_err  = 1'b0;
    unique case (x_size)
      2'b00:   x_err = 1'b0;
      2'b01:   x_err = x_addr[0];
      2'b10:   x_err = (x_addr[1:0] != 2'b00);
      default: x_err = 1'b1;
    endcase
    if (x_addr[ADDRESS_BITS-1:2] >= DEPTH_L) begin
      x_err = 1'b1;
    end

    x_word = mem_q[x_idx];
    x_byte = x_word[{x_addr[1:0], 3'b000} +: 8];
    x_half = x_addr[1] ? x_word[31:16] : x_word[15:0];
    unique case (x_size)
      2'b00:   x_load = {{24{x_sign & x_byte[7]}}, x_byte};
      2'b01:   x_load = {{16{x_sign & x_half[15]}}, x_half};
      default: x_load = x_word;
    endcase

    // Store data is right-aligned; replicate it so every candidate lane carries it.
    unique case (x_size)
      2'b00: begin
        x_be    = 4'b0001 << x_addr[1:0];
        x_lanes = {4{x_wdata[7:0]}};
      end
      2'b01: begin
        x_be    = x_addr[1] ? 4'b1100 : 4'b0011;
        x_lanes = {2{x_wdata[15:0]}};
      end
      2'b10: begin
        x_be    = 4'b1111;
        x_lanes = x_wdata;
      end
      default: begin
        x_be    = 4'b0000;
        x_lanes = x_wdata;
      end
    endcase
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    enter_resp   = 1'b0;
    resp_valid_d = resp_valid_q;
    rdata_d      = rdata_q;
    err_d        = err_q;
    unique case (state_q)
      S_IDLE: begin
        if (accept) begin
          if (LAT_ONE) begin
            enter_resp = 1'b1;
            state_d    = S_RESP;
          end else begin
            state_d = S_WAIT;
            cnt_d   = CNT_LOAD;
          end
        end
      end
      S_WAIT: begin
        if (cnt_q == 4'd0) begin
          enter_resp = 1'b1;
          state_d    = S_RESP;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_RESP: begin
        if (bus.resp_ready) begin
          state_d      = S_IDLE;
          resp_valid_d = 1'b0;
          rdata_d      = 32'd0;
          err_d        = 1'b0;
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (enter_resp) begin
      resp_valid_d = 1'b1;
      err_d        = x_err;
      rdata_d      = (x_err || x_wen) ? 32'd0 : x_load;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= S_IDLE;
      cnt_q        <= 4'd0;
      resp_valid_q <= 1'b0;
      rdata_q      <= 32'd0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      resp_valid_q <= resp_valid_d;
      rdata_q      <= rdata_d;
      err_q        <= err_d;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      addr_q  <= '0;
      wen_q   <= 1'b0;
      size_q  <= 2'b00;
      sign_q  <= 1'b0;
      wdata_q <= 32'd0;
    end else if (accept) begin
      addr_q  <= bus.req_addr;
      wen_q   <= bus.req_wen;
      size_q  <= bus.req_size;
      sign_q  <= bus.req_sign;
      wdata_q <= bus.req_wdata;
    end
  end

  // Storage survives reset; a request abandoned by reset never reaches the commit edge.
  always_ff @(posedge clk) begin
    if (rst && enter_resp && x_wen && !x_err) begin
      for (int i = 0; i < 4; i++) begin
        if (x_be[i]) begin
          mem_q[x_idx][8*i +: 8] <= x_lanes[8*i +: 8];
        end
      end
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: driver tasks push expected {err, rdata} into a queue,
// a negedge monitor pops and compares on every new response and checks its latency.
module tb_dmem_responder;

  localparam int          W     = 33;
  localparam int          DEPTH = 64;
  localparam logic [W-1:0] ERR  = 33'h1_0000_0000;

  logic       clk;
  logic       rst;
  logic [1:0] dbg_state;
  int         cyc;
  int         n_checks;
  int         n_pass;
  logic       prev_valid;

  logic [W-1:0] exp_q[$];
  int           acc_q[$];

  dmem_if #(.ADDRESS_BITS(32)) bus ();

  dmem_responder #(
    .ADDRESS_BITS(32),
    .DEPTH_WORDS (DEPTH),
    .LATENCY     (2)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus),
    .dbg_state_o(dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc = cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  // driver
  task automatic do_req(input logic [31:0] addr, input logic wen, input logic [1:0] size,
                        input logic sign, input logic [31:0] wdata,
                        input logic [W-1:0] exp, input bit expect_resp);
    int guard;
    guard = 0;
    @(negedge clk);
    bus.req_addr  = addr;
    bus.req_wen   = wen;
    bus.req_size  = size;
    bus.req_sign  = sign;
    bus.req_wdata = wdata;
    bus.req_valid = 1'b1;
    while (!bus.req_ready && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 100) begin
      check("req_ready_timeout", 33'd0, 33'd1);
      bus.req_valid = 1'b0;
      return;
    end
    if (expect_resp) exp_q.push_back(exp);
    @(posedge clk);
    #1;
    if (expect_resp) acc_q.push_back(cyc);
    bus.req_valid = 1'b0;
    bus.req_addr  = $urandom;
    bus.req_wen   = 1'($urandom_range(0, 1));
    bus.req_size  = 2'($urandom_range(0, 3));
    bus.req_sign  = 1'($urandom_range(0, 1));
    bus.req_wdata = $urandom;
  endtask

  task automatic wait_idle();
    int guard;
    guard = 0;
    @(negedge clk);
    while ((exp_q.size() != 0 || !bus.req_ready) && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 100) check("drain_timeout", 33'd0, 33'd1);
  endtask

  // scoreboard monitor
  always @(negedge clk) begin
    logic [W-1:0] e;
    int           a;
    if (!rst) begin
      prev_valid = 1'b0;
    end else begin
      if (bus.resp_valid && !prev_valid) begin
        if (exp_q.size() == 0) begin
          check("unexpected_resp", 33'd1, 33'd0);
        end else begin
          e = exp_q.pop_front();
          check("resp", {bus.resp_err, bus.resp_rdata}, e);
        end
        if (acc_q.size() != 0) begin
          a = acc_q.pop_front();
          check("latency", 33'(cyc - a), 33'd2);
        end
      end
      prev_valid = bus.resp_valid;
    end
  end

  initial begin
    int guard;
    n_checks       = 0;
    n_pass         = 0;
    cyc            = 0;
    prev_valid     = 1'b0;
    rst            = 1'b0;
    bus.req_valid  = 1'b0;
    bus.req_addr   = 32'd0;
    bus.req_wen    = 1'b0;
    bus.req_size   = 2'b00;
    bus.req_sign   = 1'b0;
    bus.req_wdata  = 32'd0;
    bus.resp_ready = 1'b1;

    repeat (3) @(posedge clk);
    #1;
    check("rst_resp_valid", 33'(bus.resp_valid), 33'd0);
    check("rst_resp_rdata", 33'(bus.resp_rdata), 33'd0);
    check("rst_resp_err",   33'(bus.resp_err),   33'd0);
    check("rst_state",      33'(dbg_state),      33'd0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("rst_req_ready", 33'(bus.req_ready), 33'd1);

    // store/load round trip and sub-word lanes
    do_req(32'h10, 1'b1, 2'b10, 1'b0, 32'hDEADBEEF, 33'h0,          1);
    do_req(32'h10, 1'b0, 2'b10, 1'b0, 32'h0,        33'h0_DEADBEEF, 1);
    do_req(32'h12, 1'b1, 2'b00, 1'b0, 32'hABCDEF7F, 33'h0,          1);
    do_req(32'h12, 1'b0, 2'b00, 1'b1, 32'h0,        33'h0_0000007F, 1);
    do_req(32'h13, 1'b0, 2'b00, 1'b1, 32'h0,        33'h0_FFFFFFDE, 1);
    do_req(32'h12, 1'b0, 2'b01, 1'b0, 32'h0,        33'h0_0000DE7F, 1);
    do_req(32'h10, 1'b0, 2'b10, 1'b0, 32'h0,        33'h0_DE7FBEEF, 1);
    do_req(32'h12, 1'b0, 2'b01, 1'b1, 32'h0,        33'h0_FFFFDE7F, 1);
    do_req(32'h13, 1'b0, 2'b00, 1'b0, 32'h0,        33'h0_000000DE, 1);
    do_req(32'h11, 1'b0, 2'b00, 1'b1, 32'h0,        33'h0_FFFFFFBE, 1);

    // faults: misaligned, reserved size, out of range; faulted stores must not write
    do_req(32'h11,  1'b0, 2'b01, 1'b0, 32'h0,        ERR, 1);
    do_req(32'h12,  1'b0, 2'b10, 1'b0, 32'h0,        ERR, 1);
    do_req(32'h10,  1'b0, 2'b11, 1'b0, 32'h0,        ERR, 1);
    do_req(32'h100, 1'b0, 2'b10, 1'b0, 32'h0,        ERR, 1);
    do_req(32'h100, 1'b1, 2'b10, 1'b0, 32'h12345678, ERR, 1);
    do_req(32'h11,  1'b1, 2'b01, 1'b0, 32'h0000FFFF, ERR, 1);
    do_req(32'h10,  1'b1, 2'b11, 1'b0, 32'h00000000, ERR, 1);
    do_req(32'h10,  1'b0, 2'b10, 1'b0, 32'h0,        33'h0_DE7FBEEF, 1);

    // half store into upper lane, top valid word
    do_req(32'h12, 1'b1, 2'b01, 1'b0, 32'h1234A55A, 33'h0,          1);
    do_req(32'h10, 1'b0, 2'b10, 1'b0, 32'h0,        33'h0_A55ABEEF, 1);
    do_req(32'hFC, 1'b1, 2'b10, 1'b0, 32'h0BADF00D, 33'h0,          1);
    do_req(32'hFC, 1'b0, 2'b10, 1'b0, 32'h0,        33'h0_0BADF00D, 1);

    // back-pressure: response held with initiator trying to store over it
    wait_idle();
    bus.resp_ready = 1'b0;
    do_req(32'h10, 1'b0, 2'b10, 1'b0, 32'h0, 33'h0_A55ABEEF, 1);
    guard = 0;
    while (!bus.resp_valid && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 20) check("resp_valid_timeout", 33'd0, 33'd1);
    for (int i = 0; i < 5; i++) begin
      bus.req_valid = 1'b1;
      bus.req_addr  = 32'h10;
      bus.req_wen   = 1'b1;
      bus.req_size  = 2'b10;
      bus.req_wdata = $urandom;
      @(negedge clk);
      check("hold_valid", 33'(bus.resp_valid), 33'd1);
      check("hold_data",  {bus.resp_err, bus.resp_rdata}, 33'h0_A55ABEEF);
      check("hold_req_ready", 33'(bus.req_ready), 33'd0);
    end
    bus.req_valid  = 1'b0;
    bus.resp_ready = 1'b1;
    @(negedge clk);
    check("turnaround_req_ready", 33'(bus.req_ready), 33'd1);
    check("turnaround_resp_valid", 33'(bus.resp_valid), 33'd0);
    do_req(32'h10, 1'b0, 2'b10, 1'b0, 32'h0, 33'h0_A55ABEEF, 1);

    // reset during WAIT abandons the store
    do_req(32'h20, 1'b1, 2'b10, 1'b0, 32'hCAFEF00D, 33'h0, 1);
    wait_idle();
    do_req(32'h20, 1'b1, 2'b10, 1'b0, 32'h11111111, 33'h0, 0);
    @(negedge clk);
    check("abort_in_wait", 33'(dbg_state), 33'd1);
    rst = 1'b0;
    #1;
    check("abort_rst_valid", 33'(bus.resp_valid), 33'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("post_rst_req_ready", 33'(bus.req_ready), 33'd1);
    check("post_rst_resp_valid", 33'(bus.resp_valid), 33'd0);
    do_req(32'h20, 1'b0, 2'b10, 1'b0, 32'h0, 33'h0_CAFEF00D, 1);

    wait_idle();
    repeat (3) @(negedge clk);
    check("queue_empty", 33'(exp_q.size()), 33'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
